ro_meas_sequencer: RTL
======================

// Module: ro_meas_sequencer
// PURPOSE
//  - Sequences ring-oscillator frequency measurement across NUM_CH oscillators that share one edge counter.
//  - For each enabled channel it selects the RO, clears the counter, opens a fixed gate window and waits for the counter to settle.
//  - It then captures the count and streams {channel, count} to the host over valid/ready.
//  - Sits between the host/readout logic and the RO mux plus edge counter.
// PARAMETERS
//  NUM_CH       3       number of RO channels (INV, NAND, NOR)
//  CH_W         2       channel index width, >= clog2(NUM_CH)
//  CNT_W        32      width of counter value / result
//  GATE_CYCLES  100000  gate window in CLK cycles (0.1 s at 1 MHz)
//  CLR_CYCLES   4       cycles cnt_clr is held before gating
//  SETTLE_CYC   8       cycles after gate close before capture (async counter freeze + sync)
// PORTS
//  CLK        in   1        system clock, 1 MHz nominal
//  RST        in   1        asynchronous reset, active-high
//  start      in   1        1-cycle request to begin a sweep; ignored while busy
//  abort      in   1        synchronous abort; wins over all other inputs except RST
//  chan_mask  in   NUM_CH   channel enables, latched on accepted start
//  ro_sel     out  CH_W     RO mux select
//  cnt_clr    out  1        clears edge counter while high
//  cnt_gate   out  1        counter counts RO edges while high
//  cnt_value  in   CNT_W    counter value, already resynchronised to CLK
//  busy       out  1        high from accepted start until return to IDLE
//  done       out  1        1-cycle pulse when sweep completes normally
//  err_empty  out  1        1-cycle pulse when start seen with chan_mask==0
//  res_valid  out  1        result available
//  res_ready  in   1        host accepts result
//  res_chan   out  CH_W     channel of result
//  res_count  out  CNT_W    captured edge count
// BEHAVIOUR
//  Reset values:
//  - ro_sel=0, cnt_clr=1, cnt_gate=0.
//  - busy=0, done=0, err_empty=0.
//  - res_valid=0, res_chan=0, res_count=0.
//  - State is IDLE.
//  States: IDLE -> CLEAR -> GATE -> SETTLE -> CAPTURE -> NEXT -> (CLEAR | DONE) -> IDLE.
//  IDLE:
//  - cnt_clr=1, cnt_gate=0.
//  - start with mask!=0: latch mask; ro_sel=lowest set bit; busy=1; -> CLEAR.
//  - start with mask==0: err_empty pulse; stay IDLE.
//  CLEAR: cnt_clr=1 for exactly CLR_CYCLES cycles, then -> GATE.
//  GATE: cnt_clr=0, cnt_gate=1 for exactly GATE_CYCLES cycles, then -> SETTLE.
//  SETTLE: cnt_gate=0 for SETTLE_CYC cycles; ro_sel held.
//  CAPTURE:
//  - On entry: res_count<=cnt_value, res_chan<=ro_sel, res_valid<=1.
//  - Hold until res_valid&&res_ready, then clear res_valid; -> NEXT.
//  - Backpressure stalls the sweep indefinitely; counter is not cleared while stalled.
//  NEXT:
//  - next set mask bit above ro_sel -> ro_sel<=it, -> CLEAR.
//  - none -> DONE.
//  DONE: done=1 for one cycle, busy<=0, -> IDLE.
//  Timer:
//  - Single down-counter, width clog2(max(GATE_CYCLES,CLR_CYCLES,SETTLE_CYC)+1).
//  - Reloaded on each state entry; transition fires on the cycle it reaches 1.
//  Counts: no arithmetic on cnt_value; counter wrap is not detected (CNT_W sized for max RO freq).
//  Abort, any state:
//  - Next cycle IDLE; cnt_gate=0, cnt_clr=1, busy=0.
//  - res_valid=0; an unaccepted result is dropped; no done pulse.
//  - abort and start in the same cycle: abort wins; start is dropped.
//  Other events:
//  - start while busy: ignored, no effect on latched mask.
//  - chan_mask changes mid-sweep: no effect.
//  - RST mid-sweep: all outputs to reset values immediately.
// CONFIGURATION
//  RO_MEAS_CONT_EN defined:
//  - In NEXT with no higher channel, wrap to the lowest set mask bit and -> CLEAR.
//  - Sweeps repeat until abort; done pulses once per completed sweep, busy stays 1.
//  RO_MEAS_CONT_EN undefined: single sweep as above, no wrap logic.
// TESTING (sim with GATE_CYCLES=100, CLR_CYCLES=4, SETTLE_CYC=8)
//  mask=3'b111, start, res_ready=1, model cnt_value=chan*1000+gate edges
//   -> 3 results: chan 0,1,2 in order; cnt_gate high exactly 100 cycles each; done once; busy low after.
//  mask=3'b101
//   -> results for chan 0 and 2 only; ro_sel never 1.
//  mask=0, start
//   -> err_empty one pulse; busy stays 0; no cnt_clr drop.
//  res_ready=0 for 50 cycles in CAPTURE of chan 0
//   -> res_valid/res_count stable; cnt_gate stays 0; sweep resumes after accept.
//  abort in GATE cycle 40
//   -> next cycle IDLE, cnt_gate=0, cnt_clr=1, busy=0, no done.
//  start again -> full sweep OK.
//  RO_MEAS_CONT_EN, mask=3'b011, run 3 sweeps
//   -> result order 0,1,0,1,0,1; 3 done pulses; abort stops with busy=0.

Source files
------------

// File: rtl/ro_meas_sequencer.sv
// ----------------------------------------------------------------------------
// ro_meas_sequencer
//
// Purpose:
//   Sweeps NUM_CH ring oscillators through one shared edge counter. For each
//   enabled channel it selects the RO, holds the counter in clear, opens a
//   fixed gate window, waits for the counter to freeze and resynchronise,
//   then captures the count and offers {channel, count} to the host over a
//   valid/ready handshake.
//
// Build option:
//   RO_MEAS_CONT_EN - when defined, a finished sweep wraps back to the lowest
//                     enabled channel and repeats until abort; done_o pulses
//                     once per completed sweep and busy_o stays high.
//                     When undefined, one sweep per accepted start.
//
// Ports:
//   clk_i        system clock (1 MHz nominal)
//   rst_i        asynchronous reset, active-high
//   start_i      one-cycle sweep request, ignored while busy
//   abort_i      synchronous abort, overrides every other input but reset
//   chan_mask_i  channel enables, latched when a start is accepted
//   ro_sel_o     RO mux select
//   cnt_clr_o    edge counter clear (high in IDLE and CLEAR)
//   cnt_gate_o   edge counter gate (high in GATE only)
//   cnt_value_i  edge counter value, already synchronous to clk_i
//   busy_o       high from accepted start until back in IDLE
//   done_o       one-cycle pulse at normal sweep completion
//   err_empty_o  one-cycle pulse when start arrives with an empty mask
//   res_valid_o  result available
//   res_ready_i  host accepts result
//   res_chan_o   channel of the offered result
//   res_count_o  captured edge count
// ----------------------------------------------------------------------------
module ro_meas_sequencer #(
    parameter int NUM_CH      = 3,
    parameter int CH_W        = 2,
    parameter int CNT_W       = 32,
    parameter int GATE_CYCLES = 100000,
    parameter int CLR_CYCLES  = 4,
    parameter int SETTLE_CYC  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [NUM_CH-1:0] chan_mask_i,
    output logic [CH_W-1:0]   ro_sel_o,
    output logic              cnt_clr_o,
    output logic              cnt_gate_o,
    input  logic [CNT_W-1:0]  cnt_value_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_empty_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [CH_W-1:0]   res_chan_o,
    output logic [CNT_W-1:0]  res_count_o
);

    localparam int TMR_MAX_A = (GATE_CYCLES > CLR_CYCLES) ? GATE_CYCLES : CLR_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > SETTLE_CYC) ? TMR_MAX_A : SETTLE_CYC;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_CLR    = TMR_W'(CLR_CYCLES);
    localparam logic [TMR_W-1:0] TMR_GATE   = TMR_W'(GATE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_SETTLE = TMR_W'(SETTLE_CYC);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_GATE    = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CH_W-1:0]   ro_sel_q, ro_sel_d;
    logic              res_valid_q, res_valid_d;
    logic [CH_W-1:0]   res_chan_q, res_chan_d;
    logic [CNT_W-1:0]  res_count_q, res_count_d;
    logic              done_q, done_d;
    logic              err_empty_q, err_empty_d;
    logic [CH_W:0]     next_ch;

    // Lowest enabled channel of a mask (caller guarantees mask != 0).
    function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    // {found, channel}: lowest enabled channel strictly above cur.
    function automatic logic [CH_W:0] next_above(input logic [NUM_CH-1:0] m,
                                                 input logic [CH_W-1:0]   cur);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    assign next_ch = next_above(mask_q, ro_sel_q);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        mask_d      = mask_q;
        ro_sel_d    = ro_sel_q;
        res_valid_d = res_valid_q;
        res_chan_d  = res_chan_q;
        res_count_d = res_count_q;
        done_d      = 1'b0;
        err_empty_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (|chan_mask_i) begin
                        mask_d   = chan_mask_i;
                        ro_sel_d = lowest_set(chan_mask_i);
                        timer_d  = TMR_CLR;
                        state_d  = S_CLEAR;
                    end else begin
                        err_empty_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (timer_q == TMR_ONE) begin
                    timer_d = TMR_GATE;
                    state_d = S_GATE;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            S_GATE: begin
                if (timer_q == TMR_ONE) begin
                    timer_d = TMR_SETTLE;
                    state_d = S_SETTLE;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            S_SETTLE: begin
                // Capture happens on the transition edge so the result is
                // presented on the first CAPTURE cycle.
                if (timer_q == TMR_ONE) begin
                    res_count_d = cnt_value_i;
                    res_chan_d  = ro_sel_q;
                    res_valid_d = 1'b1;
                    state_d     = S_CAPTURE;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            S_CAPTURE: begin
                // Counter is neither cleared nor gated while the host stalls.
                if (res_valid_q && res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = S_NEXT;
                end
            end
            S_NEXT: begin
                if (next_ch[CH_W]) begin
                    ro_sel_d = next_ch[CH_W-1:0];
                    timer_d  = TMR_CLR;
                    state_d  = S_CLEAR;
                end else begin
                    done_d = 1'b1;
`ifdef RO_MEAS_CONT_EN
                    ro_sel_d = lowest_set(mask_q);
                    timer_d  = TMR_CLR;
                    state_d  = S_CLEAR;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything: pending result dropped, no pulses,
        // a simultaneous start is discarded.
        if (abort_i) begin
            state_d     = S_IDLE;
            timer_d     = timer_q;
            mask_d      = mask_q;
            ro_sel_d    = ro_sel_q;
            res_valid_d = 1'b0;
            res_chan_d  = res_chan_q;
            res_count_d = res_count_q;
            done_d      = 1'b0;
            err_empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            mask_q      <= '0;
            ro_sel_q    <= '0;
            res_valid_q <= 1'b0;
            res_chan_q  <= '0;
            res_count_q <= '0;
            done_q      <= 1'b0;
            err_empty_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            mask_q      <= mask_d;
            ro_sel_q    <= ro_sel_d;
            res_valid_q <= res_valid_d;
            res_chan_q  <= res_chan_d;
            res_count_q <= res_count_d;
            done_q      <= done_d;
            err_empty_q <= err_empty_d;
        end
    end

    // Counter controls decode straight from the state register so they
    // follow an asynchronous reset immediately.
    assign cnt_clr_o   = (state_q == S_IDLE) || (state_q == S_CLEAR);
    assign cnt_gate_o  = (state_q == S_GATE);
    assign busy_o      = (state_q != S_IDLE);
    assign ro_sel_o    = ro_sel_q;
    assign done_o      = done_q;
    assign err_empty_o = err_empty_q;
    assign res_valid_o = res_valid_q;
    assign res_chan_o  = res_chan_q;
    assign res_count_o = res_count_q;

endmodule
